imm_decode_stage: RTL and testbench

Registered, parametrised immediate-decode stage for the RISC-V core. It accepts raw 32-bit instructions through a valid/ready handshake and classifies each by format. It produces the sign- or zero-extended immediate at XLEN width, flags illegal opcodes, and buffers results in a 2-entry queue so the decode/execute boundary can stall without losing instructions. It sits between instruction fetch and the register-read/ALU stage and is the combinational immediate generator's pipelined successor.

---
 rtl/imm_decode_stage.sv | 110 +++++++++++
 tb/tb_imm_decode_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decodes RISC-V immediates and buffers results in a 2-entry queue
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);
  logic [6:0]      op;
  logic [2:0]      f3;
  logic            sh;
  logic [31:0]     i_imm;
  logic [31:0]     imm32;
  logic [2:0]      fmt;
  logic [XLEN-1:0] imm;
  logic [31:0]     q_instr [2];
  logic [XLEN-1:0] q_imm [2];
  logic [2:0]      q_fmt [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  assign op    = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign sh    = (f3 == 3'b001) || (f3 == 3'b101);
  assign i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
  // opcode map to format and 32-bit immediate; shift amounts keep bit 31 clear so widening zero-extends
  always_comb begin
    fmt   = 3'd7;
    imm32 = '0;
    case (op)
      7'b0110011: fmt = 3'd0;
      7'b0010011: begin
        fmt   = sh ? 3'd6 : 3'd1;
        imm32 = sh ? {26'b0, (XLEN == 64) ? in_instr[25] : 1'b0, in_instr[24:20]} : i_imm;
      end
      7'b0011011: begin
        fmt   = (XLEN == 64) ? (sh ? 3'd6 : 3'd1) : 3'd7;
        imm32 = (XLEN == 64) ? (sh ? {27'b0, in_instr[24:20]} : i_imm) : '0;
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt   = 3'd1;
        imm32 = i_imm;
      end
      7'b0100011: begin
        fmt   = 3'd2;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        fmt   = 3'd3;
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt   = 3'd4;
        imm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt   = 3'd5;
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end
  assign imm       = XLEN'($signed(imm32));
  assign in_ready  = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // queue state: reset clears storage, flush drops everything including this cycle's push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
      q_imm[0]   <= '0;
      q_imm[1]   <= '0;
      q_fmt[0]   <= '0;
      q_fmt[1]   <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        q_instr[wr_ptr] <= in_instr;
        q_imm[wr_ptr]   <= imm;
        q_fmt[wr_ptr]   <= fmt;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  assign out_instr   = q_instr[rd_ptr];
  assign out_imm     = q_imm[rd_ptr];
  assign out_fmt     = q_fmt[rd_ptr];
  assign out_illegal = q_fmt[rd_ptr] == 3'd7;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed checks of decode, queueing, flush and reset
module tb_imm_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic        v64 = 1'b0;
  logic        r64;
  logic [31:0] i64 = '0;
  logic        ov64;
  logic [31:0] oi64;
  logic [63:0] oimm64;
  logic [2:0]  of64;
  logic        oil64;
  int tests = 0;
  int fails = 0;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v64), .in_ready(r64),
    .in_instr(i64), .out_valid(ov64), .out_ready(1'b1), .out_instr(oi64),
    .out_imm(oimm64), .out_fmt(of64), .out_illegal(oil64)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    tests++; if (out_imm !== 32'h0) begin fails++; $display("FAIL rst_out_imm got %h exp 0", out_imm); end
    tests++; if (out_fmt !== 3'd0) begin fails++; $display("FAIL rst_out_fmt got %0d exp 0", out_fmt); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL rst_out_instr got %h exp 0", out_instr); end
    tests++; if (out_illegal !== 1'b0) begin fails++; $display("FAIL rst_out_illegal got %b exp 0", out_illegal); end
    tests++; if (ov64 !== 1'b0 || r64 !== 1'b1 || oimm64 !== 64'h0) begin fails++; $display("FAIL rst_x64 got v=%b r=%b imm=%h exp v=0 r=1 imm=0", ov64, r64, oimm64); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode32;
    logic [31:0] vi [14] = '{32'hFCE08713, 32'hFCE08703, 32'hFCE08723, 32'hFCE08763, 32'hFFDFF06F,
                             32'h00511093, 32'h40315093, 32'h123450B7, 32'h00208033, 32'h0000007F,
                             32'h02009093, 32'h0000001B, 32'h00000073, 32'hFFF08067};
    logic [31:0] ve [14] = '{32'hFFFFFFCE, 32'hFFFFFFCE, 32'hFFFFFFCE, 32'hFFFFF7CE, 32'hFFFFFFFC,
                             32'h00000005, 32'h00000003, 32'h12345000, 32'h00000000, 32'h00000000,
                             32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
    logic [2:0]  vf [14] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd6, 3'd4, 3'd0, 3'd7, 3'd6, 3'd7, 3'd1, 3'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      in_instr = vi[i];
      tick();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL dec32_valid[%0d] got %b exp 1", i, out_valid); end
      tests++; if (out_instr !== vi[i]) begin fails++; $display("FAIL dec32_instr[%0d] got %h exp %h", i, out_instr, vi[i]); end
      tests++; if (out_imm !== ve[i]) begin fails++; $display("FAIL dec32_imm[%0d] got %h exp %h", i, out_imm, ve[i]); end
      tests++; if (out_fmt !== vf[i]) begin fails++; $display("FAIL dec32_fmt[%0d] got %0d exp %0d", i, out_fmt, vf[i]); end
      tests++; if (out_illegal !== (vf[i] == 3'd7)) begin fails++; $display("FAIL dec32_illegal[%0d] got %b exp %b", i, out_illegal, vf[i] == 3'd7); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL dec32_in_ready[%0d] got %b exp 1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dec32_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_decode64;
    logic [31:0] vi [8] = '{32'h800000B7, 32'hFCE08713, 32'h0000007F, 32'h0050109B,
                            32'h02009093, 32'hFFF0809B, 32'h00511093, 32'h40315093};
    logic [63:0] ve [8] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFCE, 64'h0, 64'h5,
                            64'h20, 64'hFFFFFFFFFFFFFFFF, 64'h5, 64'h3};
    logic [2:0]  vf [8] = '{3'd4, 3'd1, 3'd7, 3'd6, 3'd6, 3'd1, 3'd6, 3'd6};
    for (int i = 0; i < 8; i++) begin
      v64 = 1'b1;
      i64 = vi[i];
      tick();
      tests++; if (ov64 !== 1'b1 || oi64 !== vi[i]) begin fails++; $display("FAIL dec64_head[%0d] got v=%b instr=%h exp v=1 instr=%h", i, ov64, oi64, vi[i]); end
      tests++; if (oimm64 !== ve[i]) begin fails++; $display("FAIL dec64_imm[%0d] got %h exp %h", i, oimm64, ve[i]); end
      tests++; if (of64 !== vf[i] || oil64 !== (vf[i] == 3'd7)) begin fails++; $display("FAIL dec64_fmt[%0d] got %0d/%b exp %0d/%b", i, of64, oil64, vf[i], vf[i] == 3'd7); end
    end
    v64 = 1'b0;
    tick();
    tests++; if (ov64 !== 1'b0) begin fails++; $display("FAIL dec64_drain got %b exp 0", ov64); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFCE08713;
    tick();
    tests++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_one got v=%b r=%b exp v=1 r=1", out_valid, in_ready); end
    in_instr = 32'h00511093;
    tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got %b exp 0", in_ready); end
    in_instr = 32'h123450B7;
    tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_held_ready got %b exp 0", in_ready); end
    tests++; if (out_instr !== 32'hFCE08713 || out_imm !== 32'hFFFFFFCE) begin fails++; $display("FAIL bp_stable got %h/%h exp fce08713/ffffffce", out_instr, out_imm); end
    out_ready = 1'b1;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_pop got %b exp 1", in_ready); end
    tests++; if (out_instr !== 32'h00511093 || out_imm !== 32'h5 || out_fmt !== 3'd6) begin fails++; $display("FAIL bp_second got %h/%h/%0d exp 00511093/5/6", out_instr, out_imm, out_fmt); end
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_instr !== 32'h123450B7 || out_imm !== 32'h12345000) begin fails++; $display("FAIL bp_third got v=%b %h/%h exp v=1 123450b7/12345000", out_valid, out_instr, out_imm); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFCE08723;
    tick();
    in_instr = 32'hFCE08763;
    tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL fl_full got %b exp 0", in_ready); end
    out_ready = 1'b1;
    flush     = 1'b1;
    in_instr  = 32'hFFDFF06F;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL fl_clear got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fl_dropped got %b exp 0", out_valid); end
    in_valid = 1'b1;
    in_instr = 32'h00208033;
    tick();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_instr !== 32'h00208033 || out_fmt !== 3'd0) begin fails++; $display("FAIL fl_resume got v=%b %h/%0d exp v=1 00208033/0", out_valid, out_instr, out_fmt); end
    tick();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFCE08713;
    tick();
    in_instr = 32'h40315093;
    tick();
    tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL rm_pre got v=%b r=%b exp v=1 r=0", out_valid, in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rm_async got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
    tests++; if (out_instr !== 32'h0 || out_imm !== 32'h0) begin fails++; $display("FAIL rm_cleared got %h/%h exp 0/0", out_instr, out_imm); end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rm_release got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_decode32();
    test_decode64();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
